// File: rtl/iob_gpio_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iob_gpio_irq: GPIO block with debounced inputs and edge interrupts   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iob_gpio_irq #(
    parameter int GPIO_W = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEB_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iob_valid,
    input  logic [ADDR_W-1:0]     iob_addr,
    input  logic [DATA_W-1:0]     iob_wdata,
    input  logic [DATA_W/8-1:0]   iob_wstrb,
    output logic [DATA_W-1:0]     iob_rdata,
    output logic                  iob_ready,
    input  logic [GPIO_W-1:0]     gpio_input,
    output logic [GPIO_W-1:0]     gpio_output,
    output logic [GPIO_W-1:0]     gpio_output_enable,
    output logic                  irq
);

    localparam int c_STRB_W = DATA_W / 8;

    logic [GPIO_W-1:0] r_out, r_oe, r_irq_en, r_rise_en, r_fall_en, r_pend;
    logic [DEB_W-1:0]  r_deb_div, r_cnt;
    logic [GPIO_W-1:0] r_sync1, r_sync2, r_samp, r_filt, r_filt_d;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;

    logic [DATA_W-1:0] w_bmask;
    logic [31:0]       w_word;
    logic              w_wr;
    logic              w_wr_out, w_wr_oe, w_wr_deb, w_wr_ien, w_wr_rise, w_wr_fall, w_wr_pend;
    logic [GPIO_W-1:0] w_gmask, w_gdata;
    logic [DEB_W-1:0]  w_dmask, w_ddata;
    logic [DATA_W-1:0] w_rd_val;
    logic              w_tick;
    logic [GPIO_W-1:0] w_stable, w_rise, w_fall, w_set, w_clr;

    // Expand byte strobes into a bit mask for the merged register writes.
    genvar gi;
    generate
        for (gi = 0; gi < c_STRB_W; gi++) begin : g_bmask
            assign w_bmask[8*gi +: 8] = {8{iob_wstrb[gi]}};
        end
    endgenerate

    assign w_word    = 32'(iob_addr >> 2);
    assign w_wr      = iob_valid & (|iob_wstrb);
    assign w_wr_out  = w_wr & (w_word == 32'd0);
    assign w_wr_oe   = w_wr & (w_word == 32'd1);
    assign w_wr_deb  = w_wr & (w_word == 32'd3);
    assign w_wr_ien  = w_wr & (w_word == 32'd4);
    assign w_wr_rise = w_wr & (w_word == 32'd5);
    assign w_wr_fall = w_wr & (w_word == 32'd6);
    assign w_wr_pend = w_wr & (w_word == 32'd7);

    assign w_gmask = w_bmask[GPIO_W-1:0];
    assign w_gdata = iob_wdata[GPIO_W-1:0];
    assign w_dmask = w_bmask[DEB_W-1:0];
    assign w_ddata = iob_wdata[DEB_W-1:0];

    always_comb begin
        w_rd_val = '0;
        case (w_word)
            32'd0:   w_rd_val[GPIO_W-1:0] = r_out;
            32'd1:   w_rd_val[GPIO_W-1:0] = r_oe;
            32'd2:   w_rd_val[GPIO_W-1:0] = r_filt;
            32'd3:   w_rd_val[DEB_W-1:0]  = r_deb_div;
            32'd4:   w_rd_val[GPIO_W-1:0] = r_irq_en;
            32'd5:   w_rd_val[GPIO_W-1:0] = r_rise_en;
            32'd6:   w_rd_val[GPIO_W-1:0] = r_fall_en;
            32'd7:   w_rd_val[GPIO_W-1:0] = r_pend;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= iob_valid;
            r_rdata <= (iob_valid && !w_wr) ? w_rd_val : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_deb_div <= '0;
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            if (w_wr_out)  r_out     <= (r_out     & ~w_gmask) | (w_gdata & w_gmask);
            if (w_wr_oe)   r_oe      <= (r_oe      & ~w_gmask) | (w_gdata & w_gmask);
            if (w_wr_deb)  r_deb_div <= (r_deb_div & ~w_dmask) | (w_ddata & w_dmask);
            if (w_wr_ien)  r_irq_en  <= (r_irq_en  & ~w_gmask) | (w_gdata & w_gmask);
            if (w_wr_rise) r_rise_en <= (r_rise_en & ~w_gmask) | (w_gdata & w_gmask);
            if (w_wr_fall) r_fall_en <= (r_fall_en & ~w_gmask) | (w_gdata & w_gmask);
        end
    end

    // A bit is accepted only when it reads the same on two consecutive ticks.
    assign w_tick   = (r_deb_div != '0) && (r_cnt == r_deb_div);
    assign w_stable = ~(r_sync2 ^ r_samp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_samp   <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= gpio_input;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            if (w_wr_deb) begin
                r_cnt <= '0;
            end else if (r_deb_div == '0) begin
                r_cnt  <= '0;
                r_filt <= r_sync2;
            end else if (w_tick) begin
                r_cnt  <= '0;
                r_samp <= r_sync2;
                r_filt <= (r_filt & ~w_stable) | (r_sync2 & w_stable);
            end else begin
                r_cnt <= r_cnt + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = w_wr_pend ? (w_gdata & w_gmask) : '0;

    // Clear is applied first so a simultaneous new event wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    assign iob_ready          = r_ready;
    assign iob_rdata          = r_rdata;
    assign gpio_output        = r_out;
    assign gpio_output_enable = r_oe;
    assign irq                = |(r_pend & r_irq_en);

endmodule
`default_nettype wire
